// File: rtl/cpu_defs.sv
// Shared definitions for the instruction fetch stage: widths, NOP encoding and FSM states.
package cpu_defs;

   localparam int AW    = 10;
   localparam int IW    = 16;
   localparam int DEPTH = 2;
   localparam logic [IW-1:0] NOP = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched words tagged with their pc; reset and flush are both synchronous.
module fetch_queue #(
   parameter int W     = 26,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push at full is accepted only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues imem requests at the current pc, queues returned words, steps the pc stage.
module instr_fetch #(
   parameter int              AW    = cpu_defs::AW,
   parameter int              IW    = cpu_defs::IW,
   parameter int              DEPTH = cpu_defs::DEPTH,
   parameter logic [IW-1:0]   NOP   = cpu_defs::NOP
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   input  logic          flush,
   input  logic          stall,
   output logic          pc_adv,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic          instr_valid,
   output logic [IW-1:0] instr,
   output logic [AW-1:0] instr_pc
);
   import cpu_defs::*;

   // state | meaning
   // IDLE  | no request outstanding; waits for queue space and no flush
   // REQ   | request at imem_addr outstanding; ack pushes the word
   // DRAIN | flushed request still outstanding; ack is swallowed

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t    state;
   logic            push;
   logic            pop;
   logic            q_full;
   logic            q_empty;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   count_next;
   logic [AW+IW-1:0] q_dout;

   assign push        = (state == REQ) && imem_ack && !flush;
   assign pc_adv      = push && !reset;
   assign instr_valid = !q_empty;
   assign pop         = instr_valid && !stall && !flush;
   assign instr       = q_empty ? NOP : q_dout[IW-1:0];
   assign instr_pc    = q_empty ? '0  : q_dout[AW+IW-1:IW];

   always_comb begin
      count_next = q_count;
      case ({push, pop})
         2'b10:   count_next = q_count + 1'b1;
         2'b01:   count_next = q_count - 1'b1;
         default: count_next = q_count;
      endcase
   end

   fetch_queue #(
      .W     (AW + IW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({imem_addr, imem_rdata}),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush && (q_count < DEPTH_C)) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            REQ: begin
               if (flush) begin
                  if (imem_ack) begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (imem_ack) begin
                  // Back-to-back fetch only if the pushed word still leaves room.
                  if (count_next < DEPTH_C) begin
                     imem_addr <= pc;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change on the falling edge, outputs checked 1 ns later.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pc = '0;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic        pc_adv;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        instr_valid;
   logic [15:0] instr;
   logic [9:0]  instr_pc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .flush       (flush),
      .stall       (stall),
      .pc_adv      (pc_adv),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and apply one input vector.
   task automatic step(input logic r, input logic f, input logic s, input logic a,
                       input logic [15:0] rd, input logic [9:0] p);
      @(negedge clk);
      reset = r; flush = f; stall = s; imem_ack = a; imem_rdata = rd; pc = p;
      #1;
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [9:0] addr);
      chk({tag, ".req"}, 32'(imem_req), 32'(req));
      chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
   endtask

   task automatic chk_head(input string tag, input logic v, input logic [15:0] ins, input logic [9:0] ipc);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      chk({tag, ".instr"}, 32'(instr), 32'(ins));
      chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
   endtask

   initial begin
      // 1: reset held, then released at pc 0
      step(1, 0, 0, 0, 16'h0000, 10'h000);
      chk_req("rst0", 0, 10'h000); chk_head("rst0", 0, 16'h0000, 10'h000);
      chk("rst0.pc_adv", 32'(pc_adv), 0);
      step(1, 0, 0, 0, 16'h0000, 10'h000);
      chk_req("rst1", 0, 10'h000); chk_head("rst1", 0, 16'h0000, 10'h000);
      step(0, 0, 0, 0, 16'h0000, 10'h000);
      chk_req("rel", 0, 10'h000);
      step(0, 0, 0, 0, 16'h0000, 10'h000);
      chk_req("t1.first_req", 1, 10'h000);

      // 2: first word returns; pc stage presents the next address with the ack
      step(0, 0, 0, 1, 16'h0BFF, 10'h001);
      chk("t2.pc_adv", 32'(pc_adv), 1);
      step(0, 0, 0, 0, 16'h0000, 10'h001);
      chk_head("t2.issue", 1, 16'h0BFF, 10'h000);
      chk_req("t2.next_req", 1, 10'h001);

      // 3: stalled downstream fills the queue, then two words issue back to back
      step(0, 0, 1, 1, 16'h1111, 10'h002);
      chk("t3.pc_adv_a", 32'(pc_adv), 1);
      chk("t3.empty", 32'(instr_valid), 0);
      step(0, 0, 1, 1, 16'h2222, 10'h003);
      chk("t3.pc_adv_b", 32'(pc_adv), 1);
      chk_req("t3.req_b", 1, 10'h002);
      step(0, 0, 1, 0, 16'h0000, 10'h003);
      chk_req("t3.full", 0, 10'h002);
      chk_head("t3.hold", 1, 16'h1111, 10'h001);
      step(0, 0, 0, 0, 16'h0000, 10'h003);
      chk_req("t3.still_full", 0, 10'h002);
      chk_head("t3.issue1", 1, 16'h1111, 10'h001);
      step(0, 0, 0, 0, 16'h0000, 10'h003);
      chk_head("t3.issue2", 1, 16'h2222, 10'h002);
      step(0, 0, 0, 0, 16'h0000, 10'h003);
      chk("t3.drained", 32'(instr_valid), 0);
      chk_req("t3.refetch", 1, 10'h003);

      // 4: flush while the request at 0x005 is pending, late ack discarded
      step(0, 0, 0, 1, 16'h3333, 10'h004);
      chk("t4.pc_adv3", 32'(pc_adv), 1);
      step(0, 0, 0, 0, 16'h0000, 10'h004);
      chk_head("t4.w3", 1, 16'h3333, 10'h003);
      step(0, 0, 0, 1, 16'h4444, 10'h005);
      chk("t4.pc_adv4", 32'(pc_adv), 1);
      step(0, 1, 0, 0, 16'h0000, 10'h3FF);
      chk_head("t4.pre_flush", 1, 16'h4444, 10'h004);
      chk_req("t4.pending", 1, 10'h005);
      chk("t4.flush_adv", 32'(pc_adv), 0);
      step(0, 0, 0, 0, 16'h0000, 10'h3FF);
      chk("t4.flushed", 32'(instr_valid), 0);
      chk_req("t4.drain_hold", 1, 10'h005);
      step(0, 1, 0, 0, 16'h0000, 10'h3FF);
      chk_req("t4.drain_hold2", 1, 10'h005);
      step(0, 0, 0, 1, 16'hDEAD, 10'h3FF);
      chk("t4.late_ack_adv", 32'(pc_adv), 0);
      step(0, 0, 0, 0, 16'h0000, 10'h3FF);
      chk_req("t4.idle", 0, 10'h005);
      chk("t4.no_push", 32'(instr_valid), 0);
      step(0, 0, 0, 0, 16'h0000, 10'h3FF);
      chk_req("t4.new_pc", 1, 10'h3FF);

      // 5: flush coinciding with ack, once with an empty queue and once with a queued word
      step(0, 1, 0, 1, 16'hBEEF, 10'h100);
      chk("t5a.adv", 32'(pc_adv), 0);
      step(0, 0, 0, 0, 16'h0000, 10'h100);
      chk_head("t5a.dropped", 0, 16'h0000, 10'h000);
      chk_req("t5a.idle", 0, 10'h3FF);
      step(0, 0, 1, 0, 16'h0000, 10'h100);
      chk_req("t5b.req", 1, 10'h100);
      step(0, 0, 1, 1, 16'h5555, 10'h101);
      chk("t5b.adv", 32'(pc_adv), 1);
      step(0, 1, 1, 1, 16'hBEEF, 10'h200);
      chk_head("t5b.queued", 1, 16'h5555, 10'h100);
      chk("t5b.flush_ack_adv", 32'(pc_adv), 0);
      step(0, 0, 1, 0, 16'h0000, 10'h200);
      chk_head("t5b.cleared", 0, 16'h0000, 10'h000);
      chk_req("t5b.idle", 0, 10'h101);
      step(0, 0, 1, 0, 16'h0000, 10'h200);
      chk_req("t5b.new_req", 1, 10'h200);

      // 6: reset in the middle of REQ, then a stale ack
      step(0, 0, 1, 1, 16'h6666, 10'h201);
      chk("t6.adv", 32'(pc_adv), 1);
      step(1, 0, 1, 1, 16'h9999, 10'h201);
      chk_head("t6.before_rst", 1, 16'h6666, 10'h200);
      chk("t6.rst_adv", 32'(pc_adv), 0);
      step(0, 0, 1, 1, 16'h7777, 10'h300);
      chk_req("t6.after_rst", 0, 10'h000);
      chk_head("t6.after_rst", 0, 16'h0000, 10'h000);
      chk("t6.stale_adv", 32'(pc_adv), 0);
      step(0, 0, 1, 0, 16'h0000, 10'h300);
      chk("t6.stale_ignored", 32'(instr_valid), 0);
      chk_req("t6.restart", 1, 10'h300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
